// File: rtl/immgen_pipe.sv
// Pipelined RISC-V immediate generator between decode and execute.
// Format decode feeds a two-entry valid/ready skid buffer with a sideband tag.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [2:0]       i_imm_sel,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [TAG_W-1:0] o_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immgen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_I     = 3'b001;
    localparam logic [2:0] SEL_S     = 3'b010;
    localparam logic [2:0] SEL_B     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_J     = 3'b101;
    localparam logic [2:0] SEL_Z     = 3'b110;
    localparam logic [2:0] SEL_SHAMT = 3'b111;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state, state_nx;

    logic [XLEN-1:0]  imm_d;
    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             in_fire, out_fire;
    logic             ld_main_in, ld_main_skid, ld_skid;
    logic             unused;

    assign unused = ^i_instr[6:0];

    always_comb begin
        imm_d = '0;
        unique case (i_imm_sel)
            SEL_NONE:  imm_d = '0;
            SEL_I:     imm_d = XLEN'($signed(i_instr[31:20]));
            SEL_S:     imm_d = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            SEL_B:     imm_d = XLEN'($signed({i_instr[31], i_instr[7],
                                              i_instr[30:25], i_instr[11:8],
                                              1'b0}));
            SEL_U:     imm_d = XLEN'($signed({i_instr[31:12], 12'b0}));
            SEL_J:     imm_d = XLEN'($signed({i_instr[31], i_instr[19:12],
                                              i_instr[20], i_instr[30:21],
                                              1'b0}));
            SEL_Z:     imm_d = XLEN'(i_instr[19:15]);
            SEL_SHAMT: begin
                if (XLEN == 32) imm_d = XLEN'(i_instr[24:20]);
                else            imm_d = XLEN'(i_instr[25:20]);
            end
            default:   imm_d = '0;
        endcase
    end

    // Handshake flags come from registered state only: no comb ready path.
    assign o_valid  = (state != EMPTY);
    assign o_ready  = (state != TWO);
    assign in_fire  = i_valid & o_ready & ~i_flush;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nx   = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nx = TWO;
                    ld_skid  = 1'b1;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nx     = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        if (i_flush) begin
            state_nx     = EMPTY;
            ld_main_skid = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= EMPTY;
            main_imm <= '0;
            main_tag <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else begin
            state <= state_nx;
            if (ld_main_in) begin
                main_imm <= imm_d;
                main_tag <= i_tag;
            end else if (ld_main_skid) begin
                main_imm <= skid_imm;
                main_tag <= skid_tag;
            end
            if (ld_skid) begin
                skid_imm <= imm_d;
                skid_tag <= i_tag;
            end
        end
    end

    assign o_imm = main_imm;
    assign o_tag = main_tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe at XLEN=32 and XLEN=64.
// Both instances share stimulus; outputs are checked after each rising edge.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;
    logic        ready;

    logic        rdy32, val32, rdy64, val64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_valid(valid), .o_ready(rdy32), .i_instr(instr),
        .i_imm_sel(sel), .i_tag(tag), .o_valid(val32),
        .i_ready(ready), .o_imm(imm32), .o_tag(tag32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_valid(valid), .o_ready(rdy64), .i_instr(instr),
        .i_imm_sel(sel), .i_tag(tag), .o_valid(val64),
        .i_ready(ready), .o_imm(imm64), .o_tag(tag64)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [31:0] ins, input logic [4:0] t);
        valid = v;
        sel   = s;
        instr = ins;
        tag   = t;
    endtask

    function automatic logic [31:0] itag(input logic [4:0] t);
        return {7'b0, t, 20'h00093};
    endfunction

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        #12;
        check("rst_valid32", val32, 0);
        check("rst_ready32", rdy32, 1);
        check("rst_imm32", imm32, 0);
        check("rst_tag32", tag32, 0);
        check("rst_valid64", val64, 0);
        check("rst_imm64", imm64, 0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", val32, 0);

        // T1..T3: back-to-back formats, one beat per cycle
        drive(1'b1, 3'b001, 32'hFFF00093, 5'd3);
        tick();
        check("t1_valid", val32, 1);
        check("t1_imm32", imm32, 64'hFFFFFFFF);
        check("t1_tag", tag32, 3);
        check("t1_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 3'b010, 32'hFE112E23, 5'd4);
        tick();
        check("s_imm32", imm32, 64'hFFFFFFFC);
        check("s_tag", tag32, 4);
        drive(1'b1, 3'b011, 32'h00000463, 5'd5);
        tick();
        check("b_imm32", imm32, 64'h8);
        check("b_imm64", imm64, 64'h8);
        drive(1'b1, 3'b110, 32'h3400A073, 5'd6);
        tick();
        check("z_imm32", imm32, 64'h1);
        drive(1'b1, 3'b100, 32'h800000B7, 5'd7);
        tick();
        check("u_imm32", imm32, 64'h80000000);
        check("u_imm64", imm64, 64'hFFFFFFFF80000000);
        drive(1'b1, 3'b111, 32'h03F09093, 5'd8);
        tick();
        check("sh_imm32", imm32, 64'h1F);
        check("sh_imm64", imm64, 64'h3F);
        drive(1'b1, 3'b101, 32'h008000EF, 5'd9);
        tick();
        check("j_pos32", imm32, 64'h8);
        drive(1'b1, 3'b101, 32'hFFDFF0EF, 5'd10);
        tick();
        check("j_neg32", imm32, 64'hFFFFFFFC);
        check("j_neg64", imm64, 64'hFFFFFFFFFFFFFFFC);
        drive(1'b1, 3'b000, 32'hFFFFFFFF, 5'd11);
        tick();
        check("none_imm32", imm32, 0);
        check("none_imm64", imm64, 0);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        check("drain_valid", val32, 0);

        // T4: backpressure fills both entries
        ready = 1'b0;
        drive(1'b1, 3'b001, itag(5'd1), 5'd1);
        tick();
        check("bp1_tag", tag32, 1);
        check("bp1_ready", rdy32, 1);
        drive(1'b1, 3'b001, itag(5'd2), 5'd2);
        tick();
        check("bp2_tag", tag32, 1);
        check("bp2_ready", rdy32, 0);
        check("bp2_imm", imm32, 1);
        drive(1'b1, 3'b001, itag(5'd3), 5'd3);
        tick();
        check("bp3_hold_tag", tag32, 1);
        check("bp3_hold_imm", imm32, 1);
        check("bp3_ready", rdy32, 0);
        ready = 1'b1;
        tick();
        check("st2_tag", tag32, 2);
        check("st2_imm", imm32, 2);
        check("st2_ready", rdy32, 1);
        tick();
        check("st3_tag", tag32, 3);
        check("st3_valid", val32, 1);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        check("st_end_valid", val32, 0);

        // T5: flush from TWO with a same-cycle input beat
        ready = 1'b0;
        drive(1'b1, 3'b001, itag(5'd4), 5'd4);
        tick();
        drive(1'b1, 3'b001, itag(5'd5), 5'd5);
        tick();
        check("pre_flush_ready", rdy32, 0);
        flush = 1'b1;
        drive(1'b1, 3'b001, itag(5'd6), 5'd6);
        tick();
        check("fl_valid", val32, 0);
        check("fl_ready", rdy32, 1);
        check("fl_valid64", val64, 0);
        flush = 1'b0;
        ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        check("fl_empty", val32, 0);
        drive(1'b1, 3'b001, itag(5'd7), 5'd7);
        tick();
        check("post_fl_tag", tag32, 7);
        check("post_fl_imm", imm32, 7);

        // T6: async reset while holding a beat
        ready = 1'b0;
        drive(1'b1, 3'b001, itag(5'd9), 5'd9);
        tick();
        check("pre_rst_valid", val32, 1);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", val32, 0);
        check("arst_imm", imm32, 0);
        check("arst_tag", tag32, 0);
        check("arst_ready", rdy32, 1);
        #2;
        rst_n = 1'b1;
        ready = 1'b1;
        drive(1'b1, 3'b001, itag(5'd10), 5'd10);
        tick();
        check("rel_valid", val32, 1);
        check("rel_tag", tag32, 10);
        check("rel_imm64", imm64, 10);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        check("rel_drain", val32, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
